// File: rtl/shared_reg_arb_pkg.sv
// Shared types and defaults for the shared-register arbiter.
// Holds the FSM state enum, default sizes and the one-hot helper.
package shared_reg_arb_pkg;

  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int MAXBURST = 4;
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Widest requester count supported; onehot() is sized for it.
  localparam int MAX_NREQ = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [3:0] idx);
    return MAX_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr, wrapping.
// Self-contained so other arbiters can instantiate it.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared DW-bit register.
// One owner at a time; optional locked bursts of up to MAXBURST captures.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int NREQ     = shared_reg_arb_pkg::NREQ,
  parameter int DW       = shared_reg_arb_pkg::DW,
  parameter int MAXBURST = shared_reg_arb_pkg::MAXBURST,
  parameter int IDW_L    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*DW-1:0]   wdata,
  input  logic                 clr,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        q,
  output logic                 q_valid,
  output logic [IDW_L-1:0]     q_owner
);

  localparam int CW = (MAXBURST > 1) ? $clog2(MAXBURST + 1) : 1;

  state_e               state_q, state_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [IDW_L-1:0]     own_q, own_d;
  logic [IDW_L-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        q_q, q_d;
  logic                 q_valid_q, q_valid_d;
  logic [IDW_L-1:0]     q_owner_q, q_owner_d;

  logic                 found;
  logic [IDW_L-1:0]     win;
  logic [MAX_NREQ-1:0]  oh_win;
  logic                 capture;

  rr_pick #(.N(NREQ), .IW(IDW_L)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win)
  );

  // own_q mirrors the set gnt bit so the owner never has to be decoded.
  assign capture = (state_q == GRANT) && req[own_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    q_owner_d = q_owner_q;
    oh_win    = onehot(4'(win));

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = oh_win[NREQ-1:0];
          own_d   = win;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      default: begin
        if (capture && lock[own_q] && (int'(cnt_q) + 1 < MAXBURST)) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Either the burst is over or the owner withdrew: rotate past it.
          if (capture) cnt_d = cnt_q + CW'(1);
          gnt_d   = '0;
          ptr_d   = (own_q == IDW_L'(NREQ - 1)) ? '0 : own_q + IDW_L'(1);
          state_d = IDLE;
        end
      end
    endcase

    // A capture on the same edge as clr takes priority.
    if (capture) begin
      q_d       = wdata[int'(own_q)*DW +: DW];
      q_valid_d = 1'b1;
      q_owner_d = own_q;
    end else if (clr) begin
      q_d       = '0;
      q_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      own_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_owner_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_owner_q <= q_owner_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign q_owner = q_owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed table-driven bench for shared_reg_arbiter (NREQ=4, DW=8, MAXBURST=4).
// Hand sequences cover reset/idle and asynchronous reset mid-burst.
module tb_shared_reg_arbiter;
  import shared_reg_arb_pkg::*;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0]       lock;
  logic [31:0]      wdata;
  logic             clr;
  logic [3:0]       gnt;
  logic [7:0]       q;
  logic             q_valid;
  logic [IDW-1:0]   q_owner;

  int checks = 0;
  int errors = 0;

  shared_reg_arbiter #(.NREQ(4), .DW(8), .MAXBURST(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .clr     (clr),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .q_owner (q_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic        clr;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        qv;
    logic [1:0]  own;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [31:0] w,
                     input logic c, input logic [3:0] g, input logic [7:0] eq,
                     input logic ev, input logic [1:0] eo);
    vec_t v;
    v.req = r; v.lock = l; v.wdata = w; v.clr = c;
    v.gnt = g; v.q = eq; v.qv = ev; v.own = eo;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [7:0] eq,
                           input logic ev, input logic [1:0] eo);
    check({tag, ".gnt"},     32'(gnt),     32'(g));
    check({tag, ".q"},       32'(q),       32'(eq));
    check({tag, ".q_valid"}, 32'(q_valid), 32'(ev));
    check({tag, ".q_owner"}, 32'(q_owner), 32'(eo));
  endtask

  initial begin
    rst = 1'b1; req = 'x; lock = 'x; wdata = '0; clr = 1'b0;

    // Round-robin over four lanes, starting from ptr=0
    for (int i = 0; i < 4; i++) begin
      add(4'hF, 4'h0, 32'h13121110, 1'b0, 4'h1 << i, (i == 0) ? 8'h00 : 8'h10 + 8'(i - 1),
          (i != 0), 2'((i == 0) ? 0 : i - 1));
      add(4'hF, 4'h0, 32'h13121110, 1'b0, 4'h0, 8'h10 + 8'(i), 1'b1, 2'(i));
    end
    add(4'hF, 4'h0, 32'h13121110, 1'b0, 4'h1, 8'h13, 1'b1, 2'd3);
    add(4'hF, 4'h0, 32'h13121110, 1'b0, 4'h0, 8'h10, 1'b1, 2'd0);
    // Single write from lane 2
    add(4'h4, 4'h0, 32'h00A50000, 1'b0, 4'h4, 8'h10, 1'b1, 2'd0);
    add(4'h4, 4'h0, 32'h00A50000, 1'b0, 4'h0, 8'hA5, 1'b1, 2'd2);
    // Withdrawal by lane 3 in its grant cycle
    add(4'h8, 4'h0, 32'h33000000, 1'b0, 4'h8, 8'hA5, 1'b1, 2'd2);
    add(4'h0, 4'h0, 32'h33000000, 1'b0, 4'h0, 8'hA5, 1'b1, 2'd2);
    // clr coincident with a capture, then clr alone
    add(4'h1, 4'h0, 32'h0000007E, 1'b0, 4'h1, 8'hA5, 1'b1, 2'd2);
    add(4'h1, 4'h0, 32'h0000007E, 1'b1, 4'h0, 8'h7E, 1'b1, 2'd0);
    add(4'h0, 4'h0, 32'h00000000, 1'b1, 4'h0, 8'h00, 1'b0, 2'd0);
    add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0);
    // Locked burst on lane 1 capped at 4, lane 2 waiting
    add(4'h2, 4'h2, 32'h00000100, 1'b0, 4'h2, 8'h00, 1'b0, 2'd0);
    add(4'h6, 4'h2, 32'h00220100, 1'b0, 4'h2, 8'h01, 1'b1, 2'd1);
    add(4'h6, 4'h2, 32'h00220200, 1'b0, 4'h2, 8'h02, 1'b1, 2'd1);
    add(4'h6, 4'h2, 32'h00220300, 1'b0, 4'h2, 8'h03, 1'b1, 2'd1);
    add(4'h6, 4'h2, 32'h00220400, 1'b0, 4'h0, 8'h04, 1'b1, 2'd1);
    add(4'h6, 4'h2, 32'h00220500, 1'b0, 4'h4, 8'h04, 1'b1, 2'd1);
    add(4'h4, 4'h0, 32'h00220000, 1'b0, 4'h0, 8'h22, 1'b1, 2'd2);
    add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 8'h22, 1'b1, 2'd2);

    // Reset with X on req/lock, then idle for 10 cycles
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_x", 4'h0, 8'h00, 1'b0, 2'd0);
    rst = 1'b0; req = '0; lock = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_all("idle", 4'h0, 8'h00, 1'b0, 2'd0);
    end

    foreach (vecs[i]) begin
      req = vecs[i].req; lock = vecs[i].lock; wdata = vecs[i].wdata; clr = vecs[i].clr;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].qv, vecs[i].own);
    end

    // Locked burst on lane 0 (ptr=3 so lane 0 wins after skipping 3), reset mid-burst
    req = 4'h1; lock = 4'h1; wdata = 32'h00000055;
    @(posedge clk); #1;
    check_all("burst_gnt", 4'h1, 8'h22, 1'b1, 2'd2);
    @(posedge clk); #1;
    check_all("burst_cap", 4'h1, 8'h55, 1'b1, 2'd0);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 4'h0, 8'h00, 1'b0, 2'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    // ptr back at 0: lane 1 must beat lane 3
    req = 4'hA; lock = 4'h0; wdata = 32'h44003300;
    @(posedge clk); #1;
    check_all("post_rst_gnt", 4'h2, 8'h00, 1'b0, 2'd0);
    @(posedge clk); #1;
    check_all("post_rst_cap", 4'h0, 8'h33, 1'b1, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Round-robin arbiter and write sequencer for a single shared DW-bit data register built from resettable D flip-flops. NREQ requesters compete for write access. The block grants one requester at a time, captures that requester's data into the shared register, and supports locked bursts of up to MAXBURST consecutive writes. It sits between requester-side logic and any downstream consumer of the shared register contents.

Parameters:
NREQ, 4, number of requesters (2..16)
DW, 8, width of the shared register and of each requester data lane
MAXBURST, 4, maximum consecutive captures per grant (>=1)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester write request; held until serviced or withdrawn
lock  input  NREQ  per-requester burst request; sampled only for the current owner
wdata  input  NREQ*DW  packed data; lane i = wdata[i*DW +: DW]
clr  input  1  synchronous clear of the shared register
gnt  output  NREQ  registered one-hot grant (all-zero when idle)
q  output  DW  shared register contents
q_valid  output  1  q holds captured data
q_owner  output  $clog2(NREQ) (min 1)  index of the last requester captured

Behaviour:
- Reset (async, immediate, including mid-burst): state=IDLE, gnt=0, q=0, q_valid=0, q_owner=0, ptr=0, cnt=0.
- Internal: rotating priority pointer ptr. Search order is ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1. The first requester in that order with req=1 wins.
- FSM has two states, IDLE and GRANT.
- IDLE, req!=0: gnt<=onehot(winner), cnt<=0, state<=GRANT. Arbitration latency is 1 cycle from req high to gnt high.
- IDLE, req==0: stay in IDLE with gnt=0.
- GRANT, owner o = index of the set gnt bit:
  - Edge with req[o]=1 (capture): q<=wdata[o], q_valid<=1, q_owner<=o, cnt<=cnt+1.
  - After a capture, continue only if lock[o]=1 and cnt+1<MAXBURST: gnt is held and state stays GRANT.
  - Otherwise: gnt<=0, ptr<=(o+1) mod NREQ, state<=IDLE.
  - Edge with req[o]=0 (withdrawal): no capture; gnt<=0, ptr<=(o+1) mod NREQ, state<=IDLE.
- The requester sees its data captured on the edge where gnt[o]&&req[o]. It may change wdata or drop req from the following cycle.
- Throughput: a non-locked grant costs 2 cycles (IDLE + GRANT), so the maximum rate is 1 capture per 2 cycles. A locked burst of N captures takes N+1 cycles.
- gnt is never multi-hot. Only one state transition happens per edge.
- Requests from other requesters during GRANT are ignored until return to IDLE. No preemption.
- clr:
  - clr=1 with no capture on that edge: q<=0, q_valid<=0; q_owner unchanged.
  - clr=1 coincident with a capture: the capture wins (q loaded, q_valid=1).
- ptr wraps NREQ-1 -> 0. With a single persistent requester, it is re-granted every 2 cycles.
- MAXBURST=1: lock has no effect.
- X on req or lock during reset: outputs remain at reset values.

Decomposition:
- Package shared_reg_arb_pkg holds:
  - the default constants NREQ, DW, MAXBURST;
  - the state enum {IDLE, GRANT};
  - an index-width constant IDW = max(1, $clog2(NREQ));
  - a function onehot(idx).
- One combinational sub-module, rr_pick, takes req and ptr and returns found and winner index. It must be reusable by other arbiters.
- The FSM, counter, pointer and shared register stay in the top.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, all inputs 0 -> gnt=0, q=0x00, q_valid=0, q_owner=0 for 10 cycles.
2. Single write: req=4'b0100, wdata lane2=0xA5, no lock -> gnt=4'b0100 on cycle 1; at that edge q=0xA5, q_valid=1, q_owner=2; gnt=0 next cycle, ptr=3.
3. Round-robin fairness: req=4'b1111 held, lanes 0x10/0x11/0x12/0x13 -> capture order 0,1,2,3,0 with one capture every 2 cycles; q_owner sequence 0,1,2,3,0.
4. Locked burst limit: req[1]=1, lock[1]=1, MAXBURST=4, wdata lane1 = 0x01, 0x02, 0x03, 0x04, 0x05 per cycle -> exactly 4 captures (q ends 0x04); gnt[1] then drops; req[2] asserted during the burst is granted next.
5. Withdrawal and clr: req[3] dropped in its GRANT cycle -> no capture, q unchanged, ptr=0. Separately, clr=1 on a capture edge with lane0=0x7E -> q=0x7E, q_valid=1. clr=1 alone -> q=0x00, q_valid=0.
6. Reset mid-burst: rst pulsed asynchronously (between edges) during cycle 2 of a locked burst -> gnt, q, q_valid, q_owner go to 0 immediately. After release, the next grant starts from ptr=0.
